// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - DMEM responder: word RAM, GPIO/CYCLE MMIO, loader port (optional macro DMEM_CYCLE_CNT_EN)
module dmem_responder #(
   parameter int ADDR_W = 10,
   parameter int GPIO_W = 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [ADDR_W-1:0] address_DMEM,
   input  logic [31:0]       write_data_DMEM,
   input  logic              MemWrite,
   input  logic              MemRead,
   output logic [31:0]       data_DMEM,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   output logic [15:0]       ld_count,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] A_RAM_TOP  = ADDR_W'(DEPTH - 4);
   localparam logic [ADDR_W-1:0] A_GPIO_IN  = ADDR_W'(DEPTH - 3);
   localparam logic [ADDR_W-1:0] A_GPIO_OUT = ADDR_W'(DEPTH - 2);
   localparam logic [ADDR_W-1:0] A_CYCLE    = ADDR_W'(DEPTH - 1);

   logic [31:0]       mem_q [0:DEPTH-4];
   logic [GPIO_W-1:0] sync1_q;
   logic [GPIO_W-1:0] sync2_q;
   logic [GPIO_W-1:0] gpio_out_q;
   logic [GPIO_W-1:0] gpio_out_d;
   logic [15:0]       ld_count_q;
   logic [15:0]       ld_count_d;
   logic              ld_fire;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [31:0]       cycle_rd;
   logic [31:0]       rdata;

   // The core always wins the single write port; the loader only fills idle cycles.
   // Nothing is written while reset is asserted, even if a handshake is pending.
   assign ld_ready = ~MemWrite;
   assign ld_fire  = ld_valid & ~MemWrite & RSTn;

   // Select the source of this cycle's write.
   always_comb begin
      wr_en   = (MemWrite & RSTn) | ld_fire;
      wr_addr = ld_addr;
      wr_data = ld_data;
      if (MemWrite) begin
         wr_addr = address_DMEM;
         wr_data = write_data_DMEM;
      end
   end

   // Next state for the GPIO output register and the loader transfer counter.
   always_comb begin
      gpio_out_d = gpio_out_q;
      ld_count_d = ld_count_q + {15'd0, ld_fire};
      if (wr_en && (wr_addr == A_GPIO_OUT)) begin
         gpio_out_d = wr_data[GPIO_W-1:0];
      end
   end

   // Control registers and the two-flop synchronizer for the external inputs.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         gpio_out_q <= '0;
         ld_count_q <= '0;
      end else begin
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         gpio_out_q <= gpio_out_d;
         ld_count_q <= ld_count_d;
      end
   end

`ifdef DMEM_CYCLE_CNT_EN
   logic [31:0] cycle_q;
   logic [31:0] cycle_d;

   // Free-running cycle counter; wraps naturally at 32 bits.
   always_comb begin
      cycle_d = cycle_q + 32'd1;
   end

   // Cycle counter register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end

   assign cycle_rd = cycle_q;
`else
   assign cycle_rd = '0;
`endif

   // RAM array is deliberately not reset; MMIO words never land in it.
   always_ff @(posedge CLK) begin
      if (wr_en && (wr_addr <= A_RAM_TOP)) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Zero-latency read path; a same-cycle write is seen only after the edge.
   always_comb begin
      rdata = '0;
      if (address_DMEM == A_GPIO_IN) begin
         rdata = {{(32-GPIO_W){1'b0}}, sync2_q};
      end else if (address_DMEM == A_GPIO_OUT) begin
         rdata = {{(32-GPIO_W){1'b0}}, gpio_out_q};
      end else if (address_DMEM == A_CYCLE) begin
         rdata = cycle_rd;
      end else begin
         rdata = mem_q[address_DMEM];
      end
   end

   assign data_DMEM = MemRead ? rdata : 32'd0;
   assign gpio_out  = gpio_out_q;
   assign ld_count  = ld_count_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the single-cycle RISC-V core. It sits on the other end of the core's DMEM interface: word address, write data, MemWrite, MemRead and read data.
- Holds a word-addressed data RAM plus three memory-mapped I/O words at the top of the address space: GPIO out, GPIO in and cycle counter.
- Has a secondary valid/ready loader port so a testbench or boot loader can fill memory without stalling the core.

Parameters:
ADDR_W, 10, word-address width; fixed by the core's address_DMEM.
GPIO_W, 8, width of GPIO input and output.

Ports:
CLK  input  1  system clock, all state on rising edge
RSTn  input  1  asynchronous active-low reset
address_DMEM  input  ADDR_W  word address from core
write_data_DMEM  input  32  store data from core
MemWrite  input  1  core store strobe, one cycle per store
MemRead  input  1  core load strobe
data_DMEM  output  32  load data to core, combinational
ld_valid  input  1  loader write request
ld_ready  output  1  loader write can be accepted this cycle
ld_addr  input  ADDR_W  loader word address
ld_data  input  32  loader write data
ld_count  output  16  number of accepted loader writes
gpio_in  input  GPIO_W  asynchronous external inputs
gpio_out  output  GPIO_W  GPIO output register

Behaviour:
Address map:
- 0 .. 2^ADDR_W-4: RAM.
- 2^ADDR_W-3 (0x3FD): GPIO_IN, read-only, zero-extended.
- 2^ADDR_W-2 (0x3FE): GPIO_OUT, read/write, low GPIO_W bits.
- 2^ADDR_W-1 (0x3FF): CYCLE, read-only.

Reset (RSTn low, asynchronous):
- gpio_out=0, cycle counter=0, GPIO sync flops=0, ld_count=0.
- RAM contents are not reset and are undefined after power-up.

Reads:
- data_DMEM is combinational from address_DMEM when MemRead=1; 0 when MemRead=0.
- Zero latency, because the core consumes the data in the same cycle.
- Reading an address that is being written in the same cycle returns the old value; the new value is visible from the next cycle.

Core writes:
- When MemWrite=1, write_data_DMEM is stored at address_DMEM on the rising edge.
- Writes to GPIO_OUT update gpio_out with write_data_DMEM[GPIO_W-1:0].
- Writes to GPIO_IN and CYCLE are silently ignored.
- MemRead and MemWrite are never both high (core guarantee); if they are, the write happens and data_DMEM still returns the old value.

Loader handshake:
- ld_ready = !MemWrite. The core always has priority and is never stalled.
- Transfer occurs on a rising edge where ld_valid && ld_ready; it writes ld_data to ld_addr using the same map rules as core writes.
- ld_count increments by 1 per transfer and wraps 0xFFFF -> 0.
- While ld_valid=1 and not yet accepted, ld_addr and ld_data are held stable by the loader.
- ld_valid may deassert only after acceptance.
- Reset mid-handshake: no write occurs, ld_count=0.

GPIO_IN:
- gpio_in passes through a 2-flop synchronizer.
- A reads returns the second-stage value: 2-cycle latency from an input change to visibility.

CYCLE:
- 32-bit counter, +1 every clock after reset release, wraps 0xFFFFFFFF -> 0.
- A read returns the pre-edge value of the current cycle.

Optional Feature:
DMEM_CYCLE_CNT_EN.
- Defined: the CYCLE register exists as above.
- Undefined: no counter flops; reads of 0x3FF return 0; writes are ignored.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then core stores 0xDEADBEEF to 0x010 (MemWrite 1 cycle); next cycle MemRead at 0x010 -> data_DMEM=0xDEADBEEF. In the store cycle, a read of 0x010 returns the old value.
2. ld_valid=1, ld_addr=0x020, ld_data=0x12345678, MemWrite=1 for 2 cycles then 0 -> ld_ready low 2 cycles, then a single write on the 3rd edge; ld_count 0->1; core read of 0x020 -> 0x12345678.
3. Core writes 0x000000A5 to 0x3FE -> gpio_out=0xA5 next cycle. Write to 0x3FF -> counter unaffected. Write to 0x3FD -> ignored.
4. gpio_in changes 0x00->0x3C -> read of 0x3FD returns 0 for 2 edges, then 0x0000003C.
5. DMEM_CYCLE_CNT_EN defined: read 0x3FF at cycles N and N+5 -> difference 5. Counter preset by force to 0xFFFFFFFF -> next value 0. Macro undefined -> read 0x3FF = 0.
6. Assert RSTn low mid-loader-handshake while gpio_out=0xFF -> gpio_out=0, ld_count=0 and the counter=0 immediately (asynchronously), and no loader write occurs.
